// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data-memory controller.
// Optional host burst reads are enabled by defining HOST_BURST_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    CORE_OWN = 2'd0,
    TO_HOST  = 2'd1,
    HOST_OWN = 2'd2,
    TO_CORE  = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bank index: the bank_w bits directly above the in-bank offset.
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int off_w,
                                          input int bank_w);
    logic [31:0] mask;
    mask = (32'd1 << bank_w) - 32'd1;
    return (addr >> off_w) & mask;
  endfunction

  // In-bank word offset: the low off_w address bits.
  function automatic logic [31:0] offset_of(input logic [31:0] addr, input int off_w);
    logic [31:0] mask;
    mask = (32'd1 << off_w) - 32'd1;
    return addr & mask;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM bank, one-cycle read latency, contents not reset.
module dmem_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write at the issuing edge, or register the addressed word for a read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_bank_ctrl.sv
// Banked data-memory controller: core/host arbitration driven by t_cs with
// lossless handover, single-cycle host req/ack handshake.
// Define HOST_BURST_EN for multi-beat host reads (host_len port).
module dmem_bank_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int BANKS      = 4,
  parameter int BANK_DEPTH = 256,
  parameter int ADDR_W     = $clog2(BANKS * BANK_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t_cs,
  input  logic              core_en,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
`ifdef HOST_BURST_EN
  input  logic [7:0]        host_len,
`endif
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata
);

  localparam int OFF_W   = $clog2(BANK_DEPTH);
  localparam int BANK_W  = ADDR_W - OFF_W;
  localparam int BANK_IW = (BANK_W > 0) ? BANK_W : 1;

  state_e state_q, state_d;
  logic   core_rv_q, core_rv_d;
  logic   ack_q, ack_d;
  logic   ack_rd_q, ack_rd_d;
  logic [BANK_IW-1:0] rsel_q, rsel_d;
  logic [DATA_W-1:0]  core_hold_q, core_hold_d;
  logic [DATA_W-1:0]  host_hold_q, host_hold_d;

  logic               core_go, host_acc, host_iss, burst_act;
  logic               iss_en, iss_we;
  logic [ADDR_W-1:0]  iss_addr;
  logic [DATA_W-1:0]  iss_wdata;
  logic [BANK_IW-1:0] iss_bank;
  logic [OFF_W-1:0]   iss_off;
  logic [BANKS-1:0][DATA_W-1:0] bank_rdata;
  logic [DATA_W-1:0]  rd_mux;

`ifdef HOST_BURST_EN
  logic [7:0]        beats_q, beats_d;   // beats still to issue after the current one
  logic [ADDR_W-1:0] baddr_q, baddr_d;   // address of the next burst beat
  assign burst_act = (beats_q != 8'd0);
`else
  assign burst_act = 1'b0;
`endif

  // Stall is combinational so a core access in the t_cs-rise cycle is blocked.
  assign core_stall = t_cs | (state_q != CORE_OWN);
  assign core_go    = core_en & ~core_stall;
  // No new host access once t_cs drops: the FSM is about to hand back.
  assign host_acc   = (state_q == HOST_OWN) & t_cs & host_req & ~ack_q & ~burst_act;
  assign host_iss   = host_acc | burst_act;

  // Ownership FSM; a host burst in progress holds off the return to core.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CORE_OWN: if (t_cs) state_d = TO_HOST;
      TO_HOST:  state_d = HOST_OWN;
      HOST_OWN: if (!t_cs && !burst_act) state_d = TO_CORE;
      TO_CORE:  state_d = CORE_OWN;
      default:  state_d = CORE_OWN;
    endcase
  end

  // Select the single access presented to the banks this cycle.
  always_comb begin
    iss_en    = 1'b0;
    iss_we    = 1'b0;
    iss_addr  = core_addr;
    iss_wdata = core_wdata;
    if (core_go) begin
      iss_en = 1'b1;
      iss_we = (core_rw == RW_WRITE);
    end else if (burst_act) begin
      iss_en = 1'b1;
`ifdef HOST_BURST_EN
      iss_addr = baddr_q;
`endif
    end else if (host_acc) begin
      iss_en    = 1'b1;
      iss_we    = (host_rw == RW_WRITE);
      iss_addr  = host_addr;
      iss_wdata = host_wdata;
    end
  end

  assign iss_bank = BANK_IW'(bank_of(32'(iss_addr), OFF_W, BANK_W));
  assign iss_off  = OFF_W'(offset_of(32'(iss_addr), OFF_W));

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    dmem_bank #(.DATA_W(DATA_W), .DEPTH(BANK_DEPTH), .AW(OFF_W)) u_bank (
      .clk   (clk),
      .en    (iss_en && (iss_bank == BANK_IW'(b))),
      .we    (iss_we),
      .addr  (iss_off),
      .wdata (iss_wdata),
      .rdata (bank_rdata[b])
    );
  end

  assign rd_mux = bank_rdata[rsel_q];

  // Response tracking: rvalid/ack one cycle after issue, read data held between pulses.
  always_comb begin
    core_rv_d   = core_go & (core_rw == RW_READ);
    ack_d       = host_iss;
    ack_rd_d    = host_iss & ~iss_we;
    rsel_d      = (iss_en & ~iss_we) ? iss_bank : rsel_q;
    core_hold_d = core_rv_q ? rd_mux : core_hold_q;
    host_hold_d = (ack_q & ack_rd_q) ? rd_mux : host_hold_q;
`ifdef HOST_BURST_EN
    beats_d = beats_q;
    baddr_d = baddr_q;
    if (burst_act) begin
      beats_d = beats_q - 8'd1;
      baddr_d = baddr_q + ADDR_W'(1);
    end else if (host_acc && host_rw == RW_READ) begin
      beats_d = host_len;
      baddr_d = host_addr + ADDR_W'(1);
    end
`endif
  end

  // Controller state; reset drops any pending rvalid/ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CORE_OWN;
      core_rv_q   <= 1'b0;
      ack_q       <= 1'b0;
      ack_rd_q    <= 1'b0;
      rsel_q      <= '0;
      core_hold_q <= '0;
      host_hold_q <= '0;
`ifdef HOST_BURST_EN
      beats_q     <= '0;
      baddr_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      core_rv_q   <= core_rv_d;
      ack_q       <= ack_d;
      ack_rd_q    <= ack_rd_d;
      rsel_q      <= rsel_d;
      core_hold_q <= core_hold_d;
      host_hold_q <= host_hold_d;
`ifdef HOST_BURST_EN
      beats_q     <= beats_d;
      baddr_q     <= baddr_d;
`endif
    end
  end

  assign core_rvalid = core_rv_q;
  assign core_rdata  = core_rv_q ? rd_mux : core_hold_q;
  assign host_ack    = ack_q;
  assign host_rdata  = (ack_q & ack_rd_q) ? rd_mux : host_hold_q;

endmodule

// File: tb/tb_dmem_bank_ctrl.sv
// Scoreboard bench for dmem_bank_ctrl: drivers push expected responses,
// a negedge monitor pops and compares on core_rvalid / host_ack.
module tb_dmem_bank_ctrl;
  import dmem_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset, t_cs, core_en, core_rw, host_req, host_rw;
  logic [AW-1:0] core_addr, host_addr;
  logic [DW-1:0] core_wdata, host_wdata, core_rdata, host_rdata;
  logic          core_rvalid, core_stall, host_ack;
`ifdef HOST_BURST_EN
  logic [7:0]    host_len;
`endif

  dmem_bank_ctrl #(.DATA_W(DW), .BANKS(4), .BANK_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .t_cs(t_cs),
    .core_en(core_en), .core_rw(core_rw), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_rvalid(core_rvalid), .core_stall(core_stall),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr),
    .host_wdata(host_wdata),
`ifdef HOST_BURST_EN
    .host_len(host_len),
`endif
    .host_ack(host_ack), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int host_acks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int due; } cexp_t;
  typedef struct { logic rd; logic [DW-1:0] data; } hexp_t;
  cexp_t cq[$];
  hexp_t hq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every response the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (core_rvalid) begin
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("FAIL core_rvalid_unexpected: got rvalid with data %h, expected none", core_rdata);
      end else begin
        cexp_t e;
        e = cq.pop_front();
        chk("core_rdata", 32'(core_rdata), 32'(e.data));
        chk("core_rvalid_cycle", cyc, e.due);
      end
    end
    if (host_ack) begin
      host_acks++;
      if (hq.size() == 0) begin
        checks++; errors++;
        $display("FAIL host_ack_unexpected: got ack with data %h, expected none", host_rdata);
      end else begin
        hexp_t h;
        h = hq.pop_front();
        if (h.rd) chk("host_rdata", 32'(host_rdata), 32'(h.data));
      end
    end
  end

  // Drivers are entered at a negedge and return at a negedge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic core_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_en = 1'b1; core_rw = RW_WRITE; core_addr = a; core_wdata = d;
    @(negedge clk);
    core_en = 1'b0;
  endtask

  task automatic core_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    cexp_t e;
    e.data = exp; e.due = cyc + 1;
    cq.push_back(e);
    core_en = 1'b1; core_rw = RW_READ; core_addr = a;
    @(negedge clk);
    core_en = 1'b0;
  endtask

  // Host single access; waits (bounded) for the ack, optionally drops t_cs in the ack cycle.
  task automatic host_op(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp, input logic drop_tcs, output int ack_cyc);
    hexp_t h;
    bit got;
    got = 0;
    ack_cyc = -1;
    h.rd = rw; h.data = exp;
    hq.push_back(h);
    host_req = 1'b1; host_rw = rw; host_addr = a; host_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_ack) begin got = 1; ack_cyc = cyc; break; end
    end
    host_req = 1'b0;
    if (drop_tcs) t_cs = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL host_ack_timeout: got no ack for addr %h, expected one", a);
      void'(hq.pop_back());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rise, ack_c, a_before;
    reset = 1'b1; t_cs = 1'b0; core_en = 1'b0; core_rw = 1'b0; core_addr = '0;
    core_wdata = '0; host_req = 1'b0; host_rw = 1'b0; host_addr = '0; host_wdata = '0;
`ifdef HOST_BURST_EN
    host_len = 8'd0;
`endif
    // Reset values
    idle(2);
    chk("rst_core_rdata", 32'(core_rdata), 32'h0);
    chk("rst_core_rvalid", 32'(core_rvalid), 32'h0);
    chk("rst_host_ack", 32'(host_ack), 32'h0);
    chk("rst_host_rdata", 32'(host_rdata), 32'h0);
    chk("rst_core_stall_lo", 32'(core_stall), 32'h0);
    t_cs = 1'b1; #1;
    chk("rst_core_stall_hi", 32'(core_stall), 32'h1);
    t_cs = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(1);

    // Write then read-back, and bank non-aliasing
    core_wr(10'h105, 16'hA5A5);
    core_rd(10'h105, 16'hA5A5);
    core_wr(10'h005, 16'h0001);
    core_wr(10'h205, 16'h0002);
    core_rd(10'h005, 16'h0001);
    core_rd(10'h205, 16'h0002);
    core_rd(10'h105, 16'hA5A5);
    idle(2);

    // Host request while core owns memory: never accepted
    a_before = host_acks;
    host_req = 1'b1; host_rw = RW_READ; host_addr = 10'h105;
    idle(4);
    host_req = 1'b0;
    chk("no_ack_in_core_own", host_acks, a_before);

    // t_cs rises in the cycle after a core read issue
    cq.push_back('{data: 16'hA5A5, due: cyc + 1});
    core_en = 1'b1; core_rw = RW_READ; core_addr = 10'h105;
    @(negedge clk);
    t_cs = 1'b1; rise = cyc;
    core_rw = RW_WRITE; core_addr = 10'h005; core_wdata = 16'hDEAD; // must be stalled
    #1;
    chk("stall_on_tcs_rise", 32'(core_stall), 32'h1);
    host_op(RW_READ, 10'h105, 16'h0, 16'hA5A5, 1'b0, ack_c);
    chk("handover_ack_cycle", ack_c, rise + 3);
    core_en = 1'b0;

    // Host write, t_cs dropped in its ack cycle
    host_op(RW_WRITE, 10'h3FF, 16'h1234, 16'h0, 1'b1, ack_c);
    @(negedge clk);
    chk("stall_to_core", 32'(core_stall), 32'h1);
    @(negedge clk);
    chk("stall_released", 32'(core_stall), 32'h0);
    core_rd(10'h3FF, 16'h1234);
    core_rd(10'h005, 16'h0001);
    idle(2);

`ifdef HOST_BURST_EN
    // Burst read wrapping past the top address
    t_cs = 1'b1;
    host_op(RW_WRITE, 10'h3FE, 16'hBEEF, 16'h0, 1'b0, ack_c);
    host_op(RW_WRITE, 10'h000, 16'h0AAA, 16'h0, 1'b0, ack_c);
    host_op(RW_WRITE, 10'h001, 16'h0F0F, 16'h0, 1'b0, ack_c);
    hq.push_back('{rd: 1'b1, data: 16'hBEEF});
    hq.push_back('{rd: 1'b1, data: 16'h1234});
    hq.push_back('{rd: 1'b1, data: 16'h0AAA});
    hq.push_back('{rd: 1'b1, data: 16'h0F0F});
    host_len = 8'd3; host_req = 1'b1; host_rw = RW_READ; host_addr = 10'h3FE;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (host_ack) begin got = 1; break; end
      end
      host_req = 1'b0;
      chk("burst_first_ack", 32'(got), 32'h1);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("burst_ack_b2b", 32'(host_ack), 32'h1);
      end
    end
    host_len = 8'd0;
    t_cs = 1'b0;
    idle(3);
`endif

    // Reset during an accepted host read, before its ack is seen
    t_cs = 1'b1;
    idle(3);
    host_req = 1'b1; host_rw = RW_READ; host_addr = 10'h105;
    @(posedge clk); #1;
    reset = 1'b1; host_req = 1'b0; t_cs = 1'b0;
    #1;
    chk("rstmid_state", 32'(dut.state_q), 32'(CORE_OWN));
    chk("rstmid_core_stall", 32'(core_stall), 32'h0);
    @(negedge clk);
    chk("rstmid_host_ack", 32'(host_ack), 32'h0);
    chk("rstmid_host_rdata", 32'(host_rdata), 32'h0);
    chk("rstmid_core_rvalid", 32'(core_rvalid), 32'h0);
    chk("rstmid_core_rdata", 32'(core_rdata), 32'h0);
    reset = 1'b0;
    idle(2);
    core_rd(10'h3FF, 16'h1234);
    idle(3);

    chk("core_queue_empty", cq.size(), 0);
    chk("host_queue_empty", hq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
